// File: rtl/digit_shift_buf.sv
// digit_shift_buf: multi-mode digit shift register holding an operand as it is typed
module digit_shift_buf #(
   parameter int COUNT = 4,
   parameter int WIDTH = 4
) (
   input  logic                       trig,
   input  logic                       reset,
   input  logic                       en,
   input  logic [2:0]                 op,
   input  logic                       dir,
   input  logic [WIDTH-1:0]           in,
   input  logic [COUNT*WIDTH-1:0]     load_data,
   output logic [COUNT*WIDTH-1:0]     out,
   output logic [WIDTH-1:0]           shift_out,
   output logic [$clog2(COUNT+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);
   localparam int N  = COUNT*WIDTH;
   localparam int CW = $clog2(COUNT+1);
   localparam logic [2:0] OP_PUSH = 3'b001, OP_POP = 3'b010, OP_ROT = 3'b011,
                          OP_LOAD = 3'b100, OP_CLR = 3'b101;

   logic [N-1:0]     nxt_out;
   logic [WIDTH-1:0] nxt_sh, top, bot;
   logic [CW-1:0]    nxt_cnt;
   logic             nxt_ovf;

   assign top   = out[N-1 -: WIDTH];
   assign bot   = out[WIDTH-1:0];
   assign full  = count == CW'(COUNT);
   assign empty = count == '0;

   always_comb begin
      nxt_out = out;
      nxt_sh  = shift_out;
      nxt_cnt = count;
      nxt_ovf = overflow;
      if (en) begin
         case (op)
            OP_PUSH: begin
               nxt_out = dir ? {in, out[N-1:WIDTH]} : {out[N-WIDTH-1:0], in};
               nxt_sh  = dir ? bot : top;
               nxt_cnt = full ? count : count + CW'(1);
               nxt_ovf = overflow | full;
            end
            OP_POP: if (!empty) begin
               nxt_out = dir ? {out[N-WIDTH-1:0], WIDTH'(0)} : {WIDTH'(0), out[N-1:WIDTH]};
               nxt_sh  = dir ? top : bot;
               nxt_cnt = count - CW'(1);
            end
            OP_ROT: begin
               nxt_out = dir ? {bot, out[N-1:WIDTH]} : {out[N-WIDTH-1:0], top};
               nxt_sh  = dir ? bot : top;
            end
            OP_LOAD: begin
               nxt_out = load_data;
               nxt_sh  = '0;
               nxt_cnt = CW'(COUNT);
            end
            OP_CLR: begin
               nxt_out = '0;
               nxt_sh  = '0;
               nxt_cnt = '0;
               nxt_ovf = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge trig) begin
      if (reset) begin
         out       <= '0;
         shift_out <= '0;
         count     <= '0;
         overflow  <= 1'b0;
      end else begin
         out       <= nxt_out;
         shift_out <= nxt_sh;
         count     <= nxt_cnt;
         overflow  <= nxt_ovf;
      end
   end
endmodule

// File: doc/digit_shift_buf.md
# digit_shift_buf

- Parametrised multi-mode digit shift buffer: COUNT slots of WIDTH bits.
- Operations: push, backspace (pop), rotate, parallel load and clear, in either direction.
- Tracks occupancy with full/empty flags and a sticky overflow flag, and reports the digit expelled by the last operation.
- Sits between the keypad/digit-entry logic and the display/arithmetic datapath. It is the register that holds an operand as it is typed.

## Interface
Parameters:
- COUNT, 4, number of digit slots (≥2)
- WIDTH, 4, bits per digit (≥1)

Ports:
- trig  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  operation qualifier; 0 = hold everything
- op  in  3  000 hold, 001 push, 010 pop, 011 rotate, 100 load, 101 clear, 110/111 hold
- dir  in  1  0 = left (toward slot COUNT-1), 1 = right (toward slot 0)
- in  in  WIDTH  digit pushed by op=push
- load_data  in  COUNT*WIDTH  parallel image for op=load
- out  out  COUNT*WIDTH  buffer contents; slot k = out[k*WIDTH +: WIDTH], slot 0 least significant
- shift_out  out  WIDTH  digit expelled by the most recent push/pop/rotate
- count  out  $clog2(COUNT+1)  occupied digits, 0..COUNT
- full  out  1  count == COUNT
- empty  out  1  count == 0
- overflow  out  1  sticky; a push occurred while full

## Operation
- Registered state: out, shift_out, count, overflow. Flags full/empty decode combinationally from count.
- reset=1 at an edge: out=0, shift_out=0, count=0, overflow=0. Reset dominates en and op.
- en=0, or op = hold/110/111: all state holds.
- push, dir=0: out ← {slots COUNT-2..0, in}; shift_out ← old slot COUNT-1.
- push, dir=1: out ← {in, slots COUNT-1..1}; shift_out ← old slot 0.
- push count update: count ← min(count+1, COUNT).
- push while full: the oldest digit is dropped via shift_out, count stays COUNT, and overflow ← 1.
- pop (backspace), dir=0: out ← out >> WIDTH, zero into slot COUNT-1; shift_out ← old slot 0.
- pop, dir=1: out ← out << WIDTH, zero into slot 0; shift_out ← old slot COUNT-1.
- pop count update: count ← count-1.
- pop while empty: full no-op; out, shift_out and count are unchanged.
- rotate, dir=0: slot COUNT-1 moves to slot 0; shift_out ← that digit.
- rotate, dir=1: slot 0 moves to slot COUNT-1; shift_out ← that digit.
- rotate leaves count and overflow unchanged.
- load: out ← load_data, count ← COUNT, shift_out ← 0, overflow unchanged.
- clear: identical effect to reset.
- overflow is cleared only by reset or clear.
- Arithmetic: count never wraps. It saturates at COUNT on push and at 0 on pop.

## Timing
- Every operation has single-cycle latency. Results are visible on out/shift_out/count immediately after the qualifying trig edge.
- full and empty follow count in the same cycle, with no extra latency.
- One operation per cycle; back-to-back operations on consecutive edges are supported with no bubbles.
- Inputs (en, op, dir, in, load_data) are sampled only at the rising edge. There is no input handshake; the producer holds en high for exactly the cycles it wants applied.
- Reset asserted mid-sequence aborts any operation in that cycle; the next edge with reset=0 acts on a cleared buffer.

## Test plan
Parameters for all scenarios: COUNT=4, WIDTH=4.
1. Fill: reset, then push dir=0 with in=1,2,3,4 on four consecutive edges → out=16'h1234, count=4, full=1, empty=0, overflow=0, shift_out=0.
2. Overflow: from 16'h1234, push dir=0 in=5 → out=16'h2345, shift_out=1, count=4, overflow=1. Then clear → out=0, count=0, overflow=0, empty=1.
3. Backspace: from 16'h2345 (count=4), pop dir=0 → out=16'h0234, shift_out=5, count=3.
   - Three more pops → out=0, count=0, empty=1.
   - A fifth pop → no change, shift_out still 2.
4. Rotate: from 16'h1234, rotate dir=1 → out=16'h4123, shift_out=4, count unchanged. Then rotate dir=0 → out=16'h1234, shift_out=4.
5. Load/reset priority: load with load_data=16'hABCD → out=16'hABCD, count=4, full=1. Then reset=1 with en=1, op=push, in=7 → out=0, count=0, shift_out=0.
6. Hold/invalid: en=0 with op=push, and en=1 with op=3'b111 → out, count, shift_out and overflow all unchanged for both cycles.
